// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
// The address and write data follow the EX/MEM fields; read data is valid only while dm_ready is high.
interface mem_stage_if #(
    parameter int DW = 32
);
    logic          dm_req;
    logic          dm_we;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ready;
    logic [DW-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ready, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ready, dm_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: word loads/stores over a multi-cycle req/ready bus, branch resolution,
// upstream stall generation and the MEM/WB register.
module mem_stage #(
    parameter int DW      = 32,
    parameter int RW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ex_branch,
    input  logic          i_ex_memread,
    input  logic          i_ex_memwrite,
    input  logic          i_ex_regwrite,
    input  logic          i_ex_zero,
    input  logic [DW-1:0] i_ex_alu,
    input  logic [DW-1:0] i_ex_wdata,
    input  logic [RW-1:0] i_ex_rd,
    mem_stage_if.master   dm,
    output logic          o_pc_src,
    output logic          o_mem_stall,
    output logic          o_wb_regwrite,
    output logic          o_wb_memtoreg,
    output logic [DW-1:0] o_wb_alu,
    output logic [DW-1:0] o_wb_rdata,
    output logic [RW-1:0] o_wb_rd,
    output logic          o_mem_err
);

    // A counter of at least one bit keeps TIMEOUT == 0 (never abort) legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;

    logic w_memop;
    logic w_misaligned;
    logic w_access;
    logic w_req;
    logic w_timeout;
    logic w_stall;
    logic w_bubble;

    assign w_memop      = i_ex_memread | i_ex_memwrite;
    assign w_misaligned = w_memop & (i_ex_alu[1:0] != 2'b00);
    assign w_access     = w_memop & ~w_misaligned;

    assign w_req     = ~rst & (((r_state == S_IDLE) & w_access) | (r_state == S_ACCESS));
    assign w_timeout = (TIMEOUT != 0) & ~rst & (r_state == S_ACCESS) & ~dm.dm_ready
                       & (r_cnt == CW'(TIMEOUT));
    assign w_stall   = w_req & ~dm.dm_ready & ~w_timeout;
    assign w_bubble  = w_stall | w_misaligned | w_timeout;

    assign dm.dm_req   = w_req;
    assign dm.dm_we    = i_ex_memwrite;
    assign dm.dm_addr  = i_ex_alu;
    assign dm.dm_wdata = i_ex_wdata;

    assign o_pc_src    = ~rst & i_ex_branch & i_ex_zero;
    assign o_mem_stall = w_stall;

    // Access FSM; the wait counter saturates rather than wrapping when aborts are disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access && !dm.dm_ready) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= CW'(1);
                    end
                end
                default: begin
                    if (dm.dm_ready || w_timeout) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // MEM/WB register: bubbles while stalled, on misalignment and on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wb_regwrite <= 1'b0;
            o_wb_memtoreg <= 1'b0;
            o_wb_alu      <= '0;
            o_wb_rdata    <= '0;
            o_wb_rd       <= '0;
            o_mem_err     <= 1'b0;
        end else begin
            o_mem_err <= w_misaligned | w_timeout;
            if (w_bubble) begin
                o_wb_regwrite <= 1'b0;
                o_wb_memtoreg <= 1'b0;
                o_wb_alu      <= '0;
                o_wb_rdata    <= '0;
                o_wb_rd       <= '0;
            end else begin
                o_wb_regwrite <= i_ex_regwrite;
                o_wb_memtoreg <= i_ex_memread;
                o_wb_alu      <= i_ex_alu;
                o_wb_rdata    <= i_ex_memread ? dm.dm_rdata : '0;
                o_wb_rd       <= i_ex_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT = 4): expected MEM/WB contents are queued when each
// instruction is driven and popped after the capturing edge.
module tb_mem_stage;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        exBranch, exMemread, exMemwrite, exRegwrite, exZero;
    logic [31:0] exAlu, exWdata;
    logic [4:0]  exRd;
    logic        pcSrc, memStall;
    logic        wbRegwrite, wbMemtoreg, memErr;
    logic [31:0] wbAlu, wbRdata;
    logic [4:0]  wbRd;

    wb_t sbQ[$];
    int  vectors;
    int  miscompares;

    mem_stage_if #(.DW(32)) dmBus ();

    mem_stage #(.DW(32), .RW(5), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_ex_branch   (exBranch),
        .i_ex_memread  (exMemread),
        .i_ex_memwrite (exMemwrite),
        .i_ex_regwrite (exRegwrite),
        .i_ex_zero     (exZero),
        .i_ex_alu      (exAlu),
        .i_ex_wdata    (exWdata),
        .i_ex_rd       (exRd),
        .dm            (dmBus.master),
        .o_pc_src      (pcSrc),
        .o_mem_stall   (memStall),
        .o_wb_regwrite (wbRegwrite),
        .o_wb_memtoreg (wbMemtoreg),
        .o_wb_alu      (wbAlu),
        .o_wb_rdata    (wbRdata),
        .o_wb_rd       (wbRd),
        .o_mem_err     (memErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic wb_t bubble(input logic err);
        wb_t w;
        w = '0;
        w.err = err;
        return w;
    endfunction

    function automatic wb_t capt(input logic rw, input logic mr, input logic [31:0] alu,
                                 input logic [31:0] rdata, input logic [4:0] rd);
        wb_t w;
        w.regwrite = rw;
        w.memtoreg = mr;
        w.alu      = alu;
        w.rdata    = rdata;
        w.rd       = rd;
        w.err      = 1'b0;
        return w;
    endfunction

    task automatic applyStimulus(input logic br, input logic mr, input logic mw, input logic rw,
                                 input logic z, input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic rdy, input logic [31:0] rdata);
        exBranch       = br;
        exMemread      = mr;
        exMemwrite     = mw;
        exRegwrite     = rw;
        exZero         = z;
        exAlu          = alu;
        exWdata        = wd;
        exRd           = rd;
        dmBus.dm_ready = rdy;
        dmBus.dm_rdata = rdata;
    endtask

    // Checks combinational outputs mid-cycle, then the MEM/WB contents after the edge.
    task automatic checkOutput(input string tag, input logic expReq, input logic expStall,
                               input logic expPc, input wb_t expWb);
        wb_t w;
        @(negedge clk);
        check1({tag, ".req"},   {31'd0, dmBus.dm_req}, {31'd0, expReq});
        check1({tag, ".stall"}, {31'd0, memStall},     {31'd0, expStall});
        check1({tag, ".pc"},    {31'd0, pcSrc},        {31'd0, expPc});
        if (expReq) begin
            check1({tag, ".we"},    {31'd0, dmBus.dm_we}, {31'd0, exMemwrite});
            check1({tag, ".addr"},  dmBus.dm_addr,        exAlu);
            check1({tag, ".wdata"}, dmBus.dm_wdata,       exWdata);
        end
        sbQ.push_back(expWb);
        @(posedge clk);
        #1;
        w = sbQ.pop_front();
        check1({tag, ".wb_rw"},    {31'd0, wbRegwrite}, {31'd0, w.regwrite});
        check1({tag, ".wb_m2r"},   {31'd0, wbMemtoreg}, {31'd0, w.memtoreg});
        check1({tag, ".wb_alu"},   wbAlu,               w.alu);
        check1({tag, ".wb_rdata"}, wbRdata,             w.rdata);
        check1({tag, ".wb_rd"},    {27'd0, wbRd},       {27'd0, w.rd});
        check1({tag, ".err"},      {31'd0, memErr},     {31'd0, w.err});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(1, 1, 0, 1, 1, 32'h100, 0, 5'd5, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check1("rst.req",   {31'd0, dmBus.dm_req}, 32'd0);
        check1("rst.stall", {31'd0, memStall},     32'd0);
        check1("rst.pc",    {31'd0, pcSrc},        32'd0);
        check1("rst.wb_rw", {31'd0, wbRegwrite},   32'd0);
        check1("rst.err",   {31'd0, memErr},       32'd0);
        rst = 1'b0;

        $display("[TB] zero-wait load");
        applyStimulus(0, 1, 0, 1, 0, 32'h100, 0, 5'd5, 1, 32'hDEADBEEF);
        checkOutput("load0", 1, 0, 0, capt(1, 1, 32'h100, 32'hDEADBEEF, 5'd5));

        $display("[TB] store with three wait cycles");
        applyStimulus(0, 0, 1, 0, 0, 32'h200, 32'h12345678, 5'd0, 0, 32'hFFFF0000);
        for (int i = 0; i < 3; i++) checkOutput("storeWait", 1, 1, 0, bubble(0));
        dmBus.dm_ready = 1'b1;
        checkOutput("storeDone", 1, 0, 0, capt(0, 0, 32'h200, 32'h0, 5'd0));

        applyStimulus(0, 0, 0, 1, 0, 32'h55, 32'h99, 5'd7, 1, 32'h1234);
        checkOutput("alu", 0, 0, 0, capt(1, 0, 32'h55, 32'h0, 5'd7));

        $display("[TB] branches");
        applyStimulus(1, 0, 0, 0, 1, 32'h0, 0, 5'd0, 0, 0);
        checkOutput("brTaken", 0, 0, 1, capt(0, 0, 32'h0, 32'h0, 5'd0));
        applyStimulus(1, 0, 0, 0, 0, 32'h4, 0, 5'd0, 0, 0);
        checkOutput("brNot", 0, 0, 0, capt(0, 0, 32'h4, 32'h0, 5'd0));

        $display("[TB] misaligned load");
        applyStimulus(0, 1, 0, 1, 0, 32'h102, 0, 5'd9, 1, 32'hAAAA5555);
        checkOutput("misalign", 0, 0, 0, bubble(1));
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 5'd0, 0, 0);
        checkOutput("afterMis", 0, 0, 0, capt(0, 0, 32'h0, 32'h0, 5'd0));

        $display("[TB] timeout abort");
        applyStimulus(0, 1, 0, 1, 0, 32'h300, 0, 5'd3, 0, 32'h77);
        for (int i = 0; i < 4; i++) checkOutput("toWait", 1, 1, 0, bubble(0));
        checkOutput("toAbort", 1, 0, 0, bubble(1));
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 5'd0, 0, 0);
        checkOutput("afterAbort", 0, 0, 0, capt(0, 0, 32'h0, 32'h0, 5'd0));

        applyStimulus(0, 1, 0, 1, 0, 32'h304, 0, 5'd4, 0, 32'h0);
        for (int i = 0; i < 4; i++) checkOutput("lateWait", 1, 1, 0, bubble(0));
        dmBus.dm_ready = 1'b1;
        dmBus.dm_rdata = 32'hCAFEF00D;
        checkOutput("lateDone", 1, 0, 0, capt(1, 1, 32'h304, 32'hCAFEF00D, 5'd4));

        $display("[TB] reset during access");
        applyStimulus(0, 1, 0, 1, 0, 32'h400, 0, 5'd6, 0, 0);
        checkOutput("preRst", 1, 1, 0, bubble(0));
        rst = 1'b1;
        #1;
        check1("midRst.req",   {31'd0, dmBus.dm_req}, 32'd0);
        check1("midRst.stall", {31'd0, memStall},     32'd0);
        check1("midRst.wb_rw", {31'd0, wbRegwrite},   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 5'd0, 0, 0);
        checkOutput("postRstIdle", 0, 0, 0, capt(0, 0, 32'h0, 32'h0, 5'd0));
        applyStimulus(0, 1, 0, 1, 0, 32'h408, 0, 5'd8, 1, 32'h0BADC0DE);
        checkOutput("postRstLoad", 1, 0, 0, capt(1, 1, 32'h408, 32'h0BADC0DE, 5'd8));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
